// File: rtl/ibex_rf_l2_port_sched.sv
// Port scheduler for the 2-port 32x32 L2 register SRAM behind the L1 register cache.
// Arbitrates A/B miss fills and posted writebacks, with read-after-write forwarding.
module ibex_rf_l2_port_sched #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned WbDepth   = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           rd_a_req_i,
  input  logic [4:0]                     rd_a_addr_i,
  output logic                           rd_a_gnt_o,
  output logic                           rd_a_rvalid_o,
  output logic [DataWidth-1:0]           rd_a_rdata_o,
  input  logic                           rd_b_req_i,
  input  logic [4:0]                     rd_b_addr_i,
  output logic                           rd_b_gnt_o,
  output logic                           rd_b_rvalid_o,
  output logic [DataWidth-1:0]           rd_b_rdata_o,
  input  logic                           wr_req_i,
  input  logic [4:0]                     wr_addr_i,
  input  logic [DataWidth-1:0]           wr_data_i,
  output logic                           wr_gnt_o,
  output logic [4:0]                     sram_a1_o,
  output logic [4:0]                     sram_a2_o,
  output logic                           sram_web2_o,
  output logic [DataWidth-1:0]           sram_i2_o,
  input  logic [DataWidth-1:0]           sram_o1_i,
  input  logic [DataWidth-1:0]           sram_o2_i,
  output logic                           stall_o,
  output logic [$clog2(WbDepth+1)-1:0]   wb_count_o
);

  localparam int unsigned AddrW = 5;
  localparam int unsigned CntW  = $clog2(WbDepth + 1);
  localparam int unsigned NRd   = 2;

  typedef enum logic [1:0] {
    SelZero,
    SelFwd,
    SelP1,
    SelP2
  } rsel_e;

  // Write buffer: entry 0 is the oldest, entries [0, count_q) are valid
  logic [AddrW-1:0]     wb_addr_q [WbDepth];
  logic [DataWidth-1:0] wb_data_q [WbDepth];
  logic [CntW-1:0]      count_q;
  logic [CntW-1:0]      push_idx;

  logic wb_full, wb_nonempty, force_drain, opp_drain, drain;
  logic wr_req, wr_gnt, wr_push;
  logic b_on_p1, b_on_p2;

  logic [NRd-1:0]       rd_req, rd_zero, rd_fwd, rd_sram, rd_gnt;
  logic [AddrW-1:0]     rd_addr  [NRd];
  logic [DataWidth-1:0] fwd_data [NRd];
  rsel_e                sel_d    [NRd];

  logic                 buf_hit, new_hit;
  logic [DataWidth-1:0] buf_data;

  logic [NRd-1:0]       rvalid_q;
  rsel_e                sel_q    [NRd];
  logic [DataWidth-1:0] fwd_q    [NRd];
  logic [DataWidth-1:0] hold_q   [NRd];
  logic [DataWidth-1:0] rdata    [NRd];

  // Reset masks every request so grants, drains and stall stay quiet
  assign rd_req      = {rd_b_req_i, rd_a_req_i} & {NRd{~rst_i}};
  assign rd_addr[0]  = rd_a_addr_i;
  assign rd_addr[1]  = rd_b_addr_i;
  assign wr_req      = wr_req_i & ~rst_i;
  assign wb_full     = ~rst_i & (count_q == CntW'(WbDepth));
  assign wb_nonempty = ~rst_i & (count_q != '0);
  assign force_drain = wb_full;
  assign wr_gnt      = wr_req & (~wb_full | force_drain);
  assign wr_push     = wr_gnt & (wr_addr_i != '0);

  // Read classification: zero hit, incoming-write forward, buffer forward, SRAM
  always_comb begin
    rd_zero  = '0;
    rd_fwd   = '0;
    rd_sram  = '0;
    buf_hit  = 1'b0;
    new_hit  = 1'b0;
    buf_data = '0;
    for (int unsigned p = 0; p < NRd; p++) begin
      fwd_data[p] = '0;
    end
    for (int unsigned p = 0; p < NRd; p++) begin
      buf_hit  = 1'b0;
      buf_data = '0;
      for (int unsigned j = 0; j < WbDepth; j++) begin
        if ((CntW'(j) < count_q) && (wb_addr_q[j] == rd_addr[p])) begin
          buf_hit  = 1'b1;
          buf_data = wb_data_q[j];
        end
      end
      new_hit     = wr_gnt & (wr_addr_i == rd_addr[p]);
      rd_zero[p]  = rd_req[p] & (rd_addr[p] == '0);
      rd_fwd[p]   = rd_req[p] & ~rd_zero[p] & (new_hit | buf_hit);
      rd_sram[p]  = rd_req[p] & ~rd_zero[p] & ~new_hit & ~buf_hit;
      fwd_data[p] = new_hit ? wr_data_i : buf_data;
    end
  end

  assign b_on_p1   = rd_sram[1] & ~rd_sram[0];
  assign b_on_p2   = rd_sram[1] & rd_sram[0] & ~force_drain;
  assign opp_drain = ~force_drain & wb_nonempty & ~b_on_p2;
  assign drain     = force_drain | opp_drain;
  assign rd_gnt[0] = rd_req[0];
  assign rd_gnt[1] = rd_req[1] & ~(rd_sram[1] & rd_sram[0] & force_drain);
  assign push_idx  = count_q - CntW'(drain);

  // Response source for each port, latched at grant
  always_comb begin
    for (int unsigned p = 0; p < NRd; p++) begin
      sel_d[p] = SelP2;
      if (rd_zero[p])                 sel_d[p] = SelZero;
      else if (rd_fwd[p])             sel_d[p] = SelFwd;
      else if ((p == 0) || b_on_p1)   sel_d[p] = SelP1;
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NRd; p++) begin
      rdata[p] = hold_q[p];
      if (rvalid_q[p]) begin
        case (sel_q[p])
          SelZero: rdata[p] = '0;
          SelFwd:  rdata[p] = fwd_q[p];
          SelP1:   rdata[p] = sram_o1_i;
          SelP2:   rdata[p] = sram_o2_i;
          default: rdata[p] = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      rvalid_q <= '0;
      for (int unsigned p = 0; p < NRd; p++) begin
        sel_q[p]  <= SelZero;
        fwd_q[p]  <= '0;
        hold_q[p] <= '0;
      end
    end else begin
      count_q  <= count_q + CntW'(wr_push) - CntW'(drain);
      rvalid_q <= rd_gnt;
      for (int unsigned p = 0; p < NRd; p++) begin
        hold_q[p] <= rdata[p];
        if (rd_gnt[p]) begin
          sel_q[p] <= sel_d[p];
          fwd_q[p] <= fwd_data[p];
        end
      end
    end
  end

  // FIFO storage; a push into the slot vacated by a pop overrides the shift
  always_ff @(posedge clk_i) begin
    if (drain) begin
      for (int unsigned j = 0; j + 1 < WbDepth; j++) begin
        wb_addr_q[j] <= wb_addr_q[j+1];
        wb_data_q[j] <= wb_data_q[j+1];
      end
    end
    if (wr_push) begin
      for (int unsigned j = 0; j < WbDepth; j++) begin
        if (CntW'(j) == push_idx) begin
          wb_addr_q[j] <= wr_addr_i;
          wb_data_q[j] <= wr_data_i;
        end
      end
    end
  end

  assign rd_a_gnt_o    = rd_gnt[0];
  assign rd_b_gnt_o    = rd_gnt[1];
  assign wr_gnt_o      = wr_gnt;
  assign rd_a_rvalid_o = rvalid_q[0];
  assign rd_b_rvalid_o = rvalid_q[1];
  assign rd_a_rdata_o  = rdata[0];
  assign rd_b_rdata_o  = rdata[1];
  assign sram_a1_o     = rd_sram[0] ? rd_addr[0] : (b_on_p1 ? rd_addr[1] : '0);
  assign sram_a2_o     = drain ? wb_addr_q[0] : (b_on_p2 ? rd_addr[1] : '0);
  assign sram_web2_o   = ~drain;
  assign sram_i2_o     = drain ? wb_data_q[0] : '0;
  assign stall_o       = (|(rd_req & ~rd_gnt)) | (wr_req & ~wr_gnt);
  assign wb_count_o    = count_q;

endmodule

// File: tb/tb_ibex_rf_l2_port_sched.sv
// Directed bench for ibex_rf_l2_port_sched with a behavioural 2-port SRAM model.
module tb_ibex_rf_l2_port_sched;

  logic        clk_i;
  logic        rst_i;
  logic        rd_a_req_i, rd_b_req_i, wr_req_i;
  logic [4:0]  rd_a_addr_i, rd_b_addr_i, wr_addr_i;
  logic [31:0] wr_data_i;
  logic        rd_a_gnt_o, rd_b_gnt_o, wr_gnt_o;
  logic        rd_a_rvalid_o, rd_b_rvalid_o;
  logic [31:0] rd_a_rdata_o, rd_b_rdata_o;
  logic [4:0]  sram_a1_o, sram_a2_o;
  logic        sram_web2_o;
  logic [31:0] sram_i2_o, sram_o1_i, sram_o2_i;
  logic        stall_o;
  logic [1:0]  wb_count_o;

  logic [31:0] mem [32];
  int n_tests = 0;
  int n_fail  = 0;

  ibex_rf_l2_port_sched #(.DataWidth(32), .WbDepth(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd_a_req_i(rd_a_req_i), .rd_a_addr_i(rd_a_addr_i), .rd_a_gnt_o(rd_a_gnt_o),
    .rd_a_rvalid_o(rd_a_rvalid_o), .rd_a_rdata_o(rd_a_rdata_o),
    .rd_b_req_i(rd_b_req_i), .rd_b_addr_i(rd_b_addr_i), .rd_b_gnt_o(rd_b_gnt_o),
    .rd_b_rvalid_o(rd_b_rvalid_o), .rd_b_rdata_o(rd_b_rdata_o),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_gnt_o(wr_gnt_o),
    .sram_a1_o(sram_a1_o), .sram_a2_o(sram_a2_o), .sram_web2_o(sram_web2_o),
    .sram_i2_o(sram_i2_o), .sram_o1_i(sram_o1_i), .sram_o2_i(sram_o2_i),
    .stall_o(stall_o), .wb_count_o(wb_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // SRAM: one-cycle read latency on both ports, port 2 writes when web2 is low
  always @(posedge clk_i) begin
    sram_o1_i <= mem[sram_a1_o];
    sram_o2_i <= mem[sram_a2_o];
    if (!sram_web2_o) mem[sram_a2_o] <= sram_i2_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic ra, input logic [4:0] aa, input logic rb, input logic [4:0] ab,
                       input logic w, input logic [4:0] wa, input logic [31:0] wd);
    rd_a_req_i = ra; rd_a_addr_i = aa;
    rd_b_req_i = rb; rd_b_addr_i = ab;
    wr_req_i = w; wr_addr_i = wa; wr_data_i = wd;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] <= 32'h100 + 32'(i);
    mem[5] <= 32'h55; mem[6] <= 32'h66; mem[7] <= 32'h77; mem[9] <= 32'h99;

    // Reset with requests present
    rst_i = 1'b1;
    drive(1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 5'd3, 32'h1);
    check("rst_gnt_a", 32'(rd_a_gnt_o), 32'd0);
    check("rst_gnt_b", 32'(rd_b_gnt_o), 32'd0);
    check("rst_wr_gnt", 32'(wr_gnt_o), 32'd0);
    check("rst_web2", 32'(sram_web2_o), 32'd1);
    check("rst_stall", 32'(stall_o), 32'd0);
    step();
    check("rst_count", 32'(wb_count_o), 32'd0);
    check("rst_rvalid_a", 32'(rd_a_rvalid_o), 32'd0);
    check("rst_rdata_a", rd_a_rdata_o, 32'd0);
    rst_i = 1'b0;

    // A=5 and B=9 in the same cycle
    drive(1'b1, 5'd5, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0);
    check("ab_gnt_a", 32'(rd_a_gnt_o), 32'd1);
    check("ab_gnt_b", 32'(rd_b_gnt_o), 32'd1);
    check("ab_a1", 32'(sram_a1_o), 32'd5);
    check("ab_a2", 32'(sram_a2_o), 32'd9);
    check("ab_web2", 32'(sram_web2_o), 32'd1);
    check("ab_stall", 32'(stall_o), 32'd0);
    step();
    check("ab_rvalid_a", 32'(rd_a_rvalid_o), 32'd1);
    check("ab_rdata_a", rd_a_rdata_o, 32'h55);
    check("ab_rvalid_b", 32'(rd_b_rvalid_o), 32'd1);
    check("ab_rdata_b", rd_b_rdata_o, 32'h99);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    check("idle_a1", 32'(sram_a1_o), 32'd0);
    step();
    check("hold_rvalid_a", 32'(rd_a_rvalid_o), 32'd0);
    check("hold_rdata_a", rd_a_rdata_o, 32'h55);

    // Posted write r3 then opportunistic drain
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'hDEAD);
    check("w3_gnt", 32'(wr_gnt_o), 32'd1);
    check("w3_web2_pre", 32'(sram_web2_o), 32'd1);
    step();
    check("w3_count1", 32'(wb_count_o), 32'd1);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    check("w3_web2", 32'(sram_web2_o), 32'd0);
    check("w3_a2", 32'(sram_a2_o), 32'd3);
    check("w3_i2", sram_i2_o, 32'hDEAD);
    step();
    check("w3_count0", 32'(wb_count_o), 32'd0);
    check("w3_mem", mem[3], 32'hDEAD);

    // Fill the buffer while B occupies port 2, then force drains
    drive(1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 5'd10, 32'hA0);
    check("fill0_web2", 32'(sram_web2_o), 32'd1);
    step();
    check("fill0_count", 32'(wb_count_o), 32'd1);
    drive(1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 5'd11, 32'hA1);
    step();
    check("fill1_count", 32'(wb_count_o), 32'd2);
    drive(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd12, 32'hA2);
    check("force_gnt_a", 32'(rd_a_gnt_o), 32'd1);
    check("force_gnt_b", 32'(rd_b_gnt_o), 32'd0);
    check("force_stall", 32'(stall_o), 32'd1);
    check("force_wr_gnt", 32'(wr_gnt_o), 32'd1);
    check("force_web2", 32'(sram_web2_o), 32'd0);
    check("force_a2", 32'(sram_a2_o), 32'd10);
    check("force_i2", sram_i2_o, 32'hA0);
    step();
    check("force_count", 32'(wb_count_o), 32'd2);
    drive(1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
    check("retry_gnt_b", 32'(rd_b_gnt_o), 32'd1);
    check("retry_stall", 32'(stall_o), 32'd0);
    check("retry_a1", 32'(sram_a1_o), 32'd7);
    check("retry_a2", 32'(sram_a2_o), 32'd11);
    step();
    check("retry_rvalid_b", 32'(rd_b_rvalid_o), 32'd1);
    check("retry_rdata_b", rd_b_rdata_o, 32'h77);
    check("retry_count", 32'(wb_count_o), 32'd1);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    step();
    check("fill_count0", 32'(wb_count_o), 32'd0);
    check("fill_mem12", mem[12], 32'hA2);

    // Forward youngest buffered value, no port-1 access
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h1111);
    step();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h2222);
    step();
    check("fw_count", 32'(wb_count_o), 32'd1);
    drive(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    check("fw_gnt_a", 32'(rd_a_gnt_o), 32'd1);
    check("fw_a1", 32'(sram_a1_o), 32'd0);
    step();
    check("fw_rvalid_a", 32'(rd_a_rvalid_o), 32'd1);
    check("fw_rdata_a", rd_a_rdata_o, 32'h2222);

    // Same-cycle write and B read of r6
    drive(1'b0, 5'd0, 1'b1, 5'd6, 1'b1, 5'd6, 32'hABCD);
    check("sw_gnt_b", 32'(rd_b_gnt_o), 32'd1);
    check("sw_a1", 32'(sram_a1_o), 32'd0);
    step();
    check("sw_rdata_b", rd_b_rdata_o, 32'hABCD);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    step();
    check("sw_count0", 32'(wb_count_o), 32'd0);

    // Read r0 with a write to r0
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h5A5A);
    check("z_gnt_a", 32'(rd_a_gnt_o), 32'd1);
    check("z_wr_gnt", 32'(wr_gnt_o), 32'd1);
    check("z_a1", 32'(sram_a1_o), 32'd0);
    step();
    check("z_rvalid_a", 32'(rd_a_rvalid_o), 32'd1);
    check("z_rdata_a", rd_a_rdata_o, 32'd0);
    check("z_count", 32'(wb_count_o), 32'd0);

    // Reset with two entries buffered
    drive(1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 5'd20, 32'h1);
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 5'd21, 32'h2);
    step();
    check("pre_rst_count", 32'(wb_count_o), 32'd2);
    rst_i = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    check("mid_rst_web2", 32'(sram_web2_o), 32'd1);
    step();
    rst_i = 1'b0;
    check("post_rst_count", 32'(wb_count_o), 32'd0);
    check("post_rst_rvalid_a", 32'(rd_a_rvalid_o), 32'd0);
    check("post_rst_rvalid_b", 32'(rd_b_rvalid_o), 32'd0);
    #1;
    check("post_rst_web2", 32'(sram_web2_o), 32'd1);
    step();
    check("post_rst_web2_b", 32'(sram_web2_o), 32'd1);
    check("post_rst_mem20", mem[20], 32'h114);
    check("post_rst_mem21", mem[21], 32'h115);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
